// File: rtl/cvt_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : cvt_write_queue
// Purpose  : Buffers CVU write requests ({sel, row, data}) in a small FIFO and
//            drains them into the single CVT write port whenever that port is
//            not stalled. Requests to the same CVT cell issue in arrival order;
//            nothing is merged or reordered.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous, active-low reset
//            in_valid   - upstream request present
//            in_ready   - queue can accept this cycle (count < DEPTH)
//            in_sel     - target CVT column (4 bits)
//            in_row     - target CVT row (5 bits)
//            in_data    - control-vector data (64 bits)
//            stall      - CVT write port unavailable this cycle
//            W_en       - CVT write enable
//            WriteSel   - CVT write column
//            WriteReg1  - CVT write row
//            WriteData1 - CVT write data
//            count      - number of entries currently stored
// Options  : CVT_WQ_BYPASS_EN - when defined, an empty queue forwards an
//            incoming request straight to the CVT port in the same cycle
//            (zero latency) if the port is not stalled. Undefined by default,
//            in which case the CVT outputs come from registered state only.
// Revision : 1.0 - initial release
// ============================================================================
module cvt_write_queue #(
  parameter int DEPTH = 4  // power of two, 2..16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_sel,
  input  logic [4:0]               in_row,
  input  logic [63:0]              in_data,
  input  logic                     stall,
  output logic                     W_en,
  output logic [3:0]               WriteSel,
  output logic [4:0]               WriteReg1,
  output logic [63:0]              WriteData1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = 4 + 5 + 64;

  // Entry layout: {sel[3:0], row[4:0], data[63:0]}
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [CW-1:0]      cnt;

  logic               empty;
  logic               full;
  logic               bypass;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // Readiness depends on stored state only, so a full queue refuses a new
  // request even in a cycle where the head drains.
  assign in_ready = !full;

`ifdef CVT_WQ_BYPASS_EN
  // Empty queue plus free write port: hand the request straight through.
  assign bypass = empty && in_valid && !stall;
`else
  assign bypass = 1'b0;
`endif

  assign W_en = (!empty && !stall) || bypass;

  // A bypassed request is consumed without occupying a slot; it can only
  // happen while empty, so it never coincides with a pop.
  assign push = in_valid && in_ready && !bypass;
  assign pop  = W_en && !empty;

  always_comb begin
    WriteSel   = '0;
    WriteReg1  = '0;
    WriteData1 = '0;
    if (bypass) begin
      WriteSel   = in_sel;
      WriteReg1  = in_row;
      WriteData1 = in_data;
    end else if (!empty) begin
      {WriteSel, WriteReg1, WriteData1} = head;
    end
  end

  // Storage array needs no reset: its contents are only observed through
  // the head while cnt is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_sel, in_row, in_data};
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;

endmodule
`default_nettype wire

// File: tb/tb_cvt_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvt_write_queue
// Purpose  : Self-checking bench for cvt_write_queue (DEPTH = 4). A per-cycle
//            vector table covers fill under stall, full refusal and streaming
//            push/pop with pointer wrap; hand-written sequences cover the
//            single write, a stall-toggling burst and reset mid-operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cvt_write_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_sel;
  logic [4:0]    in_row;
  logic [63:0]   in_data;
  logic          stall;
  logic          W_en;
  logic [3:0]    WriteSel;
  logic [4:0]    WriteReg1;
  logic [63:0]   WriteData1;
  logic [CW-1:0] count;

  cvt_write_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_row     (in_row),
    .in_data    (in_data),
    .stall      (stall),
    .W_en       (W_en),
    .WriteSel   (WriteSel),
    .WriteReg1  (WriteReg1),
    .WriteData1 (WriteData1),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Request payload derived from a tag: {sel, row, data}.
  function automatic logic [72:0] mk(input int tag);
    logic [31:0] t;
    t  = tag;
    mk = {t[3:0], 5'(t * 7), (32'hCAFE0000 | t), ~t};
  endfunction

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int tag, input logic s);
    in_valid = v;
    {in_sel, in_row, in_data} = mk(tag);
    stall = s;
  endtask

  function automatic logic [72:0] outs();
    outs = {WriteSel, WriteReg1, WriteData1};
  endfunction

  typedef struct {
    logic v;
    int   tag;
    logic s;
    logic rdy;
    logic wen;
    int   etag;  // -1: outputs expected all zero
    int   cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input int tag, input logic s,
                     input logic rdy, input logic wen, input int etag, input int cnt);
    vec_t r;
    r.v = v; r.tag = tag; r.s = s; r.rdy = rdy; r.wen = wen; r.etag = etag; r.cnt = cnt;
    vecs.push_back(r);
  endtask

  initial begin
    logic [72:0] sb[$];
    logic [72:0] exp;
    int pushed;
    int pulses;
    logic acc;

    rst = 1'b0;
    drive(1'b0, 0, 1'b0);

    // Vector table: inputs applied before an edge, outputs sampled 1 ns later.
    add(0, 0, 0,  1, 0, -1, 0);
    add(1, 1, 1,  1, 0, -1, 0);   // fill under stall
    add(1, 2, 1,  1, 0,  1, 1);
    add(1, 3, 1,  1, 0,  1, 2);
    add(1, 4, 1,  1, 0,  1, 3);
    add(1, 5, 1,  0, 0,  1, 4);   // full: fifth refused
    add(1, 5, 1,  0, 0,  1, 4);
    add(1, 5, 0,  0, 1,  1, 4);   // pop while full: still refused
    add(0, 0, 0,  1, 1,  2, 3);
    add(0, 0, 0,  1, 1,  3, 2);
    add(0, 0, 0,  1, 1,  4, 1);
    add(0, 0, 0,  1, 0, -1, 0);   // tag 5 never appears
    add(1, 16, 1, 1, 0, -1, 0);   // prime count = 2
    add(1, 17, 1, 1, 0, 16, 1);
    for (int k = 0; k < 10; k++) add(1, 18 + k, 0, 1, 1, 16 + k, 2);
    add(0, 0, 0,  1, 1, 26, 2);
    add(0, 0, 0,  1, 1, 27, 1);
    add(0, 0, 0,  1, 0, -1, 0);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    check("reset in_ready", 73'(in_ready), 73'(1));
    check("reset W_en", 73'(W_en), 73'(0));
    check("reset count", 73'(count), 73'(0));
    check("reset outputs", outs(), 73'(0));
    @(negedge clk);
    rst = 1'b1;

    // ---------------- single write ----------------
    @(negedge clk);
    in_valid = 1'b1; in_sel = 4'd3; in_row = 5'd7; in_data = 64'hDEADBEEF_01234567; stall = 1'b0;
    exp = {4'd3, 5'd7, 64'hDEADBEEF_01234567};
    #1;
`ifdef CVT_WQ_BYPASS_EN
    check("single accept-cycle W_en", 73'(W_en), 73'(1));
    check("single accept-cycle outputs", outs(), exp);
`else
    check("single accept-cycle W_en", 73'(W_en), 73'(0));
    check("single accept-cycle in_ready", 73'(in_ready), 73'(1));
`endif
    @(negedge clk);
    in_valid = 1'b0;
    #1;
`ifdef CVT_WQ_BYPASS_EN
    check("single next W_en", 73'(W_en), 73'(0));
    check("single next count", 73'(count), 73'(0));
`else
    check("single next W_en", 73'(W_en), 73'(1));
    check("single next outputs", outs(), exp);
    check("single next count", 73'(count), 73'(1));
`endif
    @(negedge clk);
    #1;
    check("single drained count", 73'(count), 73'(0));
    check("single drained W_en", 73'(W_en), 73'(0));

    // ---------------- vector table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].tag, vecs[i].s);
      #1;
      exp = (vecs[i].etag < 0) ? 73'(0) : mk(vecs[i].etag);
      check($sformatf("vec%0d in_ready", i), 73'(in_ready), 73'(vecs[i].rdy));
      check($sformatf("vec%0d W_en", i), 73'(W_en), 73'(vecs[i].wen));
      check($sformatf("vec%0d outputs", i), outs(), exp);
      check($sformatf("vec%0d count", i), 73'(count), 73'(vecs[i].cnt));
    end

    // ---------------- stall toggling burst ----------------
    pushed = 0;
    pulses = 0;
    for (int c = 0; c < 60 && (pushed < 6 || sb.size() != 0); c++) begin
      @(negedge clk);
      drive(pushed < 6, 60 + pushed, (c % 2) == 0);
      #1;
      check($sformatf("burst c%0d count", c), 73'(count), 73'(sb.size()));
      if (stall) begin
        check($sformatf("burst c%0d W_en under stall", c), 73'(W_en), 73'(0));
        if (sb.size() != 0) check($sformatf("burst c%0d head held", c), outs(), sb[0]);
      end
      acc = in_valid && in_ready;
      if (acc) begin
        sb.push_back(mk(60 + pushed));
        pushed++;
      end
      if (W_en) begin
        pulses++;
        if (sb.size() == 0) begin
          check($sformatf("burst c%0d unexpected W_en", c), 73'(1), 73'(0));
        end else begin
          check($sformatf("burst c%0d write", c), outs(), sb[0]);
          void'(sb.pop_front());
        end
      end
    end
    @(negedge clk);
    drive(1'b0, 0, 1'b0);
    check("burst W_en pulses", 73'(pulses), 73'(6));
    check("burst leftover entries", 73'(sb.size()), 73'(0));

    // ---------------- reset mid-operation ----------------
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 40 + k, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 0, 1'b1);
    #1;
    check("pre-reset count", 73'(count), 73'(3));
    #2;
    rst = 1'b0;
    #1;
    check("async reset W_en", 73'(W_en), 73'(0));
    check("async reset count", 73'(count), 73'(0));
    check("async reset in_ready", 73'(in_ready), 73'(1));
    stall = 1'b0;
    #1;
    check("in reset unstalled W_en", 73'(W_en), 73'(0));
    check("in reset outputs", outs(), 73'(0));
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 50, 1'b0);
    #1;
`ifdef CVT_WQ_BYPASS_EN
    check("post-reset accept W_en", 73'(W_en), 73'(1));
    check("post-reset accept outputs", outs(), mk(50));
`else
    check("post-reset accept W_en", 73'(W_en), 73'(0));
`endif
    @(negedge clk);
    drive(1'b0, 0, 1'b0);
    #1;
`ifdef CVT_WQ_BYPASS_EN
    check("post-reset next W_en", 73'(W_en), 73'(0));
`else
    check("post-reset next W_en", 73'(W_en), 73'(1));
    check("post-reset next outputs", outs(), mk(50));
`endif
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (W_en) pulses++;
    end
    check("discarded entries written", 73'(pulses), 73'(0));
    check("final count", 73'(count), 73'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cvt_write_queue.md
CVT_WRITE_QUEUE -- requirements
Module: cvt_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered write requests (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream CVU write request present.
REQ-005 SHALL have port in_ready  output  1  queue can accept a request this cycle.
REQ-006 SHALL have port in_sel  input  4  target CVT column (register file 0..15).
REQ-007 SHALL have port in_row  input  5  target CVT row (basic block 0..31).
REQ-008 SHALL have port in_data  input  64  control-vector data.
REQ-009 SHALL have port stall  input  1  CVT write port unavailable this cycle.
REQ-010 SHALL have port W_en  output  1  CVT write enable.
REQ-011 SHALL have port WriteSel  output  4  CVT write column.
REQ-012 SHALL have port WriteReg1  output  5  CVT write row.
REQ-013 SHALL have port WriteData1  output  64  CVT write data.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  entries currently stored.

Function
REQ-015 SHALL store requests in a FIFO of DEPTH entries of {sel, row, data}, 73 bits each.
REQ-016 SHALL accept a request on a rising edge when in_valid and in_ready are both 1.
REQ-017 SHALL drive in_ready = (count < DEPTH), combinationally from state only, never from in_valid or stall.
REQ-018 SHALL drive W_en = (count != 0) and not stall; WriteSel, WriteReg1, WriteData1 SHALL equal the head entry's fields.
REQ-019 SHALL pop the head on a rising edge when W_en is 1.
REQ-020 SHALL give a stored request a latency of exactly 1 cycle from its accept edge to W_en, when the queue was empty and stall is low.
REQ-021 SHALL, on a simultaneous accept and pop in one cycle, leave count unchanged and preserve FIFO order.
REQ-022 SHALL, when full, deassert in_ready even if a pop occurs in the same cycle; there is no full-pass-through.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH with no entry loss.
REQ-024 SHALL hold head outputs stable while stall is 1, and SHALL NOT pop during that time.
REQ-025 SHALL drive WriteSel, WriteReg1 and WriteData1 to 0 when count == 0, unless bypass applies (REQ-030).
REQ-026 SHALL issue requests to the same {sel, row} in arrival order, with no merging or reordering.

Reset
REQ-027 SHALL, while rst is 0, force count = 0, pointers = 0, W_en = 0 and outputs = 0; in_ready SHALL be 1.
REQ-028 SHALL discard all queued entries when reset asserts mid-operation; discarded entries are never written to the CVT.
REQ-029 SHALL accept requests from the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, when macro CVT_WQ_BYPASS_EN is defined and count == 0, in_valid == 1 and stall == 0, drive W_en = 1 and in_sel, in_row, in_data straight to the outputs in the same cycle.
- In that case the request is consumed without being stored; latency is 0 cycles.
REQ-031 SHALL, when CVT_WQ_BYPASS_EN is undefined, have no combinational path from the in_* ports to the CVT outputs; REQ-020 latency applies.

Verification
REQ-032 SHALL cover single write: reset, then in_valid=1 with sel=3, row=7, data=64'hDEADBEEF_01234567 for one cycle.
- Without bypass: next cycle W_en=1, WriteSel=3, WriteReg1=7, matching data; count returns to 0.
- With bypass: the same values appear in the accept cycle.
REQ-033 SHALL cover fill under stall: stall=1, push 4 requests.
- Required: count=4, in_ready=0, fifth request not accepted, W_en=0.
- Release stall: 4 writes on 4 consecutive cycles, in push order.
REQ-034 SHALL cover simultaneous push/pop: with count=2 and stall=0, push every cycle for 10 cycles.
- Required: count stays 2, all 10 data values emerge in order, pointers wrap twice.
REQ-035 SHALL cover reset mid-operation: count=3 under stall, assert rst low asynchronously between clock edges.
- Required: W_en=0 and count=0 immediately; no queued entry appears after rst deasserts.
REQ-036 SHALL cover a stall toggling every cycle during a 6-request burst.
- Required: outputs are stable whenever stall=1, and exactly 6 W_en pulses occur with correct {sel, row, data}.
